// File: rtl/dvp_pixel_tx.sv
// dvp_pixel_tx
// DVP-style 8-bit camera transmitter. Pops RGB565 pixels from a show-ahead
// FIFO, sends each one high byte first, and wraps the bytes in VSYNC/HREF
// frame timing with programmable active area and blanking.

module dvp_pixel_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 8,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 8,
  parameter int CNT_W    = 12
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        tx_en,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        frame_done,
  output logic        pix_underrun
);

  // Frame sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBP    = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFP    = 3'd4;

  // Line length in byte clocks: two bytes per active pixel plus blanking
  localparam int LINE = 2 * H_ACTIVE + H_BLANK;

  localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(LINE - 1);
  localparam logic [CNT_W-1:0] H_ACT_BYTES  = CNT_W'(2 * H_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_LAST  = CNT_W'(V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_BP_LAST    = CNT_W'(V_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST   = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_FP_LAST    = CNT_W'(V_FP - 1);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [15:0]      pix_reg;

  logic             end_of_line;
  logic             act;
  logic             even_slot;
  logic             frame_end;
  logic             state_change;
  logic             vsync_entry;

  // The high byte goes straight from the FIFO to the wire; only the low byte
  // is replayed from pix_reg on the following odd slot.
  logic             unused_pix_hi;
  assign unused_pix_hi = ^pix_reg[15:8];

  assign end_of_line  = (h_cnt == H_LAST);
  assign act          = (state == ST_ACTIVE) && (h_cnt < H_ACT_BYTES);
  assign even_slot    = act && !h_cnt[0];
  assign pix_ready    = even_slot && pix_valid;
  assign state_change = (state_nxt != state);
  assign vsync_entry  = (state_nxt == ST_VSYNC) && (state != ST_VSYNC);

  // Next-state logic: IDLE leaves as soon as tx_en is seen, every other
  // state advances only at the end of its last line.
  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_en) begin
          state_nxt = ST_VSYNC;
        end
      end
      ST_VSYNC: begin
        if (end_of_line && (v_cnt == V_SYNC_LAST)) begin
          state_nxt = ST_VBP;
        end
      end
      ST_VBP: begin
        if (end_of_line && (v_cnt == V_BP_LAST)) begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (end_of_line && (v_cnt == V_ACT_LAST)) begin
          state_nxt = ST_VFP;
        end
      end
      ST_VFP: begin
        if (end_of_line && (v_cnt == V_FP_LAST)) begin
          frame_end = 1'b1;
          state_nxt = tx_en ? ST_VSYNC : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Horizontal byte counter: parked at 0 in IDLE, free-running per line otherwise
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
    end else if (state == ST_IDLE) begin
      h_cnt <= '0;
    end else if (end_of_line) begin
      h_cnt <= '0;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Vertical counter: completed lines within the current state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v_cnt <= '0;
    end else if (state_change) begin
      v_cnt <= '0;
    end else if ((state != ST_IDLE) && end_of_line) begin
      v_cnt <= v_cnt + 1'b1;
    end
  end

  // Capture the pixel being popped so its low byte can follow on the next slot
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_reg <= 16'h0000;
    end else if (even_slot) begin
      pix_reg <= pix_valid ? pix_data : 16'h0000;
    end
  end

  // Sticky underrun flag, cleared when a new frame begins
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_underrun <= 1'b0;
    end else if (vsync_entry) begin
      pix_underrun <= 1'b0;
    end else if (even_slot && !pix_valid) begin
      pix_underrun <= 1'b1;
    end
  end

  // Registered DVP outputs, one cycle behind the counters
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_data   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      dvp_vsync  <= (state == ST_VSYNC);
      dvp_href   <= act;
      frame_done <= frame_end;
      if (even_slot) begin
        dvp_data <= pix_valid ? pix_data[15:8] : 8'h00;
      end else if (act) begin
        dvp_data <= pix_reg[7:0];
      end else begin
        dvp_data <= 8'h00;
      end
    end
  end

endmodule

// File: doc/dvp_pixel_tx.md
Name: dvp_pixel_tx

Overview:
- DVP-style 8-bit camera-interface transmitter: the source side of the OV5640-format link.
- Pulls 16-bit RGB565 pixels from a show-ahead (first-word-fall-through) FIFO and serialises each pixel high byte first.
- Generates VSYNC/HREF frame timing with programmable active area and blanking.
- Used as a camera emulator for loopback into the capture path and as a DVP output port toward external sinks.

Parameters:
H_ACTIVE, 640, active pixels per line (2 bytes each)
H_BLANK, 160, HREF-low cycles after the active bytes of each line; must be >= 1
V_SYNC, 2, lines with VSYNC high
V_BP, 8, blank lines after VSYNC
V_ACTIVE, 480, active lines per frame
V_FP, 8, blank lines after the last active line
CNT_W, 12, width of h_cnt and v_cnt; must hold 2*H_ACTIVE+H_BLANK-1 and the largest vertical count

Ports:
sys_clk  in  1  byte clock; one DVP byte per cycle
sys_rst_n  in  1  asynchronous active-low reset
tx_en  in  1  start/continue frames; sampled only in IDLE and at the end of a frame
pix_valid  in  1  FIFO not empty; pix_data is valid
pix_data  in  16  pixel {hi, lo}, show-ahead
pix_ready  out  1  pop strobe; a pixel is consumed when pix_ready is high
dvp_vsync  out  1  frame sync, active high
dvp_href  out  1  line valid, active high
dvp_data  out  8  byte data
frame_done  out  1  one-cycle pulse at the end of each frame
pix_underrun  out  1  sticky: a pixel was needed while pix_valid was low

Behaviour:
- One clock (sys_clk); reset sys_rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, h_cnt = 0, v_cnt = 0, pix_reg = 0.
  - All outputs 0: dvp_vsync, dvp_href, dvp_data, frame_done, pix_underrun, pix_ready.
- Line period: LINE = 2*H_ACTIVE + H_BLANK cycles.
  - h_cnt runs 0..LINE-1 in every non-IDLE state and wraps to 0.
  - v_cnt counts completed lines within the current state and resets to 0 on each state change.
- States: IDLE, VSYNC, VBP, ACTIVE, VFP. Transitions occur at end-of-line (h_cnt == LINE-1):
  - IDLE -> VSYNC on the first edge where tx_en = 1; h_cnt and v_cnt start at 0.
  - VSYNC -> VBP when v_cnt == V_SYNC-1.
  - VBP -> ACTIVE when v_cnt == V_BP-1.
  - ACTIVE -> VFP when v_cnt == V_ACTIVE-1.
  - VFP -> VSYNC if tx_en = 1, else VFP -> IDLE, when v_cnt == V_FP-1. frame_done pulses on this edge.
- tx_en deasserted mid-frame: the current frame completes unchanged, then the block goes to IDLE.
- Internal byte slot: act = (state == ACTIVE) && (h_cnt < 2*H_ACTIVE).
- Pixel fetch:
  - pix_ready = act && !h_cnt[0] && pix_valid (combinational).
  - On an even act slot, pix_reg <= pix_valid ? pix_data : 16'h0000.
  - If pix_valid = 0 at an even act slot, pix_underrun is set.
  - pix_underrun clears only on entry to VSYNC or on reset.
- Registered outputs, 1-cycle latency relative to the internal counters:
  - dvp_vsync <= (state == VSYNC).
  - dvp_href <= act.
  - dvp_data <= even slot ? (pix_valid ? pix_data[15:8] : 0) : pix_reg[7:0] when act; else 0.
- Each line issues exactly H_ACTIVE pops. Total pops per frame = H_ACTIVE*V_ACTIVE.
- Byte order on the wire: hi, lo. The capture side reassembles {first, second}.
- dvp_data is 0 whenever dvp_href = 0.
- Asynchronous reset mid-frame aborts immediately: outputs go to 0; no frame_done is issued.

Test Plan:
Bench parameters for all scenarios: H_ACTIVE=4, H_BLANK=3, V_SYNC=1, V_BP=1, V_ACTIVE=2, V_FP=1 (LINE=11, frame=55 cycles).
- Reset release, tx_en=0 for 20 cycles -> all outputs 0, no pops.
- tx_en=1 at edge k with FIFO preloaded with 0x1234, 0x5678, ... (8 pixels) ->
  - dvp_vsync high for cycles k+1..k+11.
  - First HREF at k+23, lasting 8 cycles; bytes 12 34 56 78 9A BC DE F0.
  - HREF low for 3 cycles, then the second line.
  - frame_done pulses once at edge k+55.
  - Exactly 8 pops, pix_underrun = 0.
- tx_en held 1 -> frames back-to-back, next VSYNC immediately after VFP; period 55 cycles.
- tx_en dropped during the first ACTIVE line -> that frame completes with all 8 pixels, frame_done pulses, then IDLE with no VSYNC.
- FIFO holds only 3 pixels -> pixels 4..8 sent as 00 00; pix_underrun = 1 from pixel 4, cleared at the next VSYNC entry.
- sys_rst_n pulsed low mid-line -> outputs 0 within the same cycle, state IDLE; with tx_en=1 a clean frame restarts.
